fetch_ctrl: RTL and testbench

//  Sequencer for the fetch stage: owns PCSel, PC_En, IF_ID_En, IF_ID_Clr each cycle.

---
 rtl/fetch_ctrl_if.sv | 30 +++
 rtl/fetch_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bundle: request/stall inputs from hazard, ID and CP0 logic,
// and the PC / IF-ID controls plus stall counter driven back by the sequencer.
interface fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             int_req;
  logic             exc_req;
  logic             exl;
  logic             eret_d;
  logic             epc_busy;
  logic             hz_stall;
  logic             md_stall;
  logic [1:0]       jmp_type;
  logic [2:0]       PCSel;
  logic             PC_En;
  logic             IF_ID_En;
  logic             IF_ID_Clr;
  logic             exc_ack;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  int_req, exc_req, exl, eret_d, epc_busy, hz_stall, md_stall, jmp_type,
    output PCSel, PC_En, IF_ID_En, IF_ID_Clr, exc_ack, stall_cnt
  );

  modport slave (
    output int_req, exc_req, exl, eret_d, epc_busy, hz_stall, md_stall, jmp_type,
    input  PCSel, PC_En, IF_ID_En, IF_ID_Clr, exc_ack, stall_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: arbitrates exception/interrupt entry, ERET return, stalls and
// ID redirects into PCSel / PC_En / IF_ID_En / IF_ID_Clr, and counts stall cycles.
module fetch_ctrl #(
  parameter int         CNT_W      = 16,
  parameter logic [2:0] EXC_VECTOR = 3'b101,
  parameter logic [2:0] ERET_SEL   = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    ERET_WAIT = 2'd1,
    EXC_HOLD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             take_exc;
  logic [2:0]       pc_sel;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_clr;
  logic             exc_ack;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // An interrupt is only taken while not already inside a handler.
  assign take_exc = bus.exc_req | (bus.int_req & ~bus.exl);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (!pc_en) stall_cnt_q <= sat_inc(stall_cnt_q);
    end
  end

  always_comb begin
    state_nxt = state;
    pc_sel    = 3'b000;
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    if_id_clr = 1'b0;
    exc_ack   = 1'b0;
    case (state)
      RUN: begin
        if (take_exc) begin
          pc_sel    = EXC_VECTOR;
          if_id_clr = 1'b1;
          exc_ack   = 1'b1;
          state_nxt = EXC_HOLD;
        end else if (bus.eret_d && bus.epc_busy) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          state_nxt = ERET_WAIT;
        end else if (bus.eret_d) begin
          pc_sel    = ERET_SEL;
          if_id_clr = 1'b1;
        end else if (bus.hz_stall || bus.md_stall) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
        end else begin
          pc_sel = {1'b0, bus.jmp_type};
        end
      end
      ERET_WAIT: begin
        if (take_exc) begin
          pc_sel    = EXC_VECTOR;
          if_id_clr = 1'b1;
          exc_ack   = 1'b1;
          state_nxt = EXC_HOLD;
        end else if (bus.epc_busy) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
        end else begin
          pc_sel    = ERET_SEL;
          if_id_clr = 1'b1;
          state_nxt = RUN;
        end
      end
      EXC_HOLD: begin
        // One sequential fetch while CP0 EXL settles; requests wait for next cycle.
        state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
    if (reset) begin
      state_nxt = RUN;
      pc_sel    = 3'b000;
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      if_id_clr = 1'b1;
      exc_ack   = 1'b0;
    end
  end

  assign bus.PCSel     = pc_sel;
  assign bus.PC_En     = pc_en;
  assign bus.IF_ID_En  = if_id_en;
  assign bus.IF_ID_Clr = if_id_clr;
  assign bus.exc_ack   = exc_ack;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, checked against a
// behavioural model of the priority rules; a 4-bit-counter instance covers saturation.
module tb_fetch_ctrl;

  logic clk;
  logic reset;

  fetch_ctrl_if #(.CNT_W(16)) bus16 ();
  fetch_ctrl_if #(.CNT_W(4))  bus4 ();

  fetch_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
  fetch_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model state: waiting on EPC, in the cycle after handler entry, stall counts.
  bit m_wait = 0;
  bit m_hold = 0;
  int m_cnt16 = 0;
  int m_cnt4  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic i_int, input logic i_exc, input logic i_exl,
                       input logic i_eret, input logic i_busy, input logic i_hz,
                       input logic i_md, input logic [1:0] jt);
    reset          = r;
    bus16.int_req  = i_int;  bus4.int_req  = i_int;
    bus16.exc_req  = i_exc;  bus4.exc_req  = i_exc;
    bus16.exl      = i_exl;  bus4.exl      = i_exl;
    bus16.eret_d   = i_eret; bus4.eret_d   = i_eret;
    bus16.epc_busy = i_busy; bus4.epc_busy = i_busy;
    bus16.hz_stall = i_hz;   bus4.hz_stall = i_hz;
    bus16.md_stall = i_md;   bus4.md_stall = i_md;
    bus16.jmp_type = jt;     bus4.jmp_type = jt;
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle against the model, advance model.
  task automatic cycle(input logic r, input logic i_int, input logic i_exc, input logic i_exl,
                       input logic i_eret, input logic i_busy, input logic i_hz,
                       input logic i_md, input logic [1:0] jt);
    logic [2:0] e_sel;
    logic       e_pc, e_en, e_clr, e_ack;
    bit         nxt_wait;
    bit         take;
    drive(r, i_int, i_exc, i_exl, i_eret, i_busy, i_hz, i_md, jt);
    #3;
    e_sel = 3'b000; e_pc = 1'b1; e_en = 1'b1; e_clr = 1'b0; e_ack = 1'b0; nxt_wait = 0;
    take  = i_exc || (i_int && !i_exl);
    if (r) begin
      e_pc = 1'b0; e_en = 1'b0; e_clr = 1'b1;
    end else if (m_hold) begin
      e_sel = 3'b000;
    end else if (take) begin
      e_sel = 3'b101; e_clr = 1'b1; e_ack = 1'b1;
    end else if (m_wait || i_eret) begin
      if (i_busy) begin
        e_pc = 1'b0; e_en = 1'b0; nxt_wait = 1;
      end else begin
        e_sel = 3'b111; e_clr = 1'b1;
      end
    end else if (i_hz || i_md) begin
      e_pc = 1'b0; e_en = 1'b0;
    end else begin
      e_sel = {1'b0, jt};
    end
    chk("PCSel",     32'(bus16.PCSel),     32'(e_sel));
    chk("PC_En",     32'(bus16.PC_En),     32'(e_pc));
    chk("IF_ID_En",  32'(bus16.IF_ID_En),  32'(e_en));
    chk("IF_ID_Clr", 32'(bus16.IF_ID_Clr), 32'(e_clr));
    chk("exc_ack",   32'(bus16.exc_ack),   32'(e_ack));
    chk("stall_cnt16", 32'(bus16.stall_cnt), 32'(m_cnt16));
    chk("stall_cnt4",  32'(bus4.stall_cnt),  32'(m_cnt4));
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      m_cnt16 = 0; m_cnt4 = 0; m_wait = 0; m_hold = 0;
    end else begin
      if (!e_pc) begin
        m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
        m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
      end
      m_hold = e_ack;
      m_wait = nxt_wait;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    @(posedge clk);
    #1;
    // Reset for two cycles, then a free-running cycle.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    // jr held off by a 3-cycle hazard stall.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0, 2'b11);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'b11);
    chk("t2_cnt", 32'(bus16.stall_cnt), 32'd3);
    // Interrupt entry, hold cycle, then interrupt masked by EXL.
    cycle(0, 1, 0, 0, 0, 0, 0, 0, 2'b00);
    cycle(0, 1, 0, 1, 0, 0, 0, 0, 2'b00);
    cycle(0, 1, 0, 1, 0, 0, 0, 0, 2'b00);
    // ERET waits two cycles for EPC.
    cycle(0, 0, 0, 0, 1, 1, 0, 0, 2'b00);
    cycle(0, 0, 0, 0, 1, 1, 0, 0, 2'b00);
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 2'b00);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    // Exception beats ERET and beq in the same cycle.
    cycle(0, 0, 1, 0, 1, 0, 0, 0, 2'b01);
    cycle(0, 0, 1, 0, 1, 0, 0, 0, 2'b01);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    // Exception preempting ERET_WAIT.
    cycle(0, 0, 0, 0, 1, 1, 0, 0, 2'b00);
    cycle(0, 0, 1, 0, 1, 1, 0, 0, 2'b00);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    // Reset in the middle of ERET_WAIT.
    cycle(0, 0, 0, 0, 1, 1, 0, 0, 2'b00);
    cycle(1, 0, 0, 0, 1, 1, 0, 0, 2'b00);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'b10);
    // Long mult/div and hazard stall saturates the 4-bit counter.
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0, 0, (i % 2) == 0, (i % 2) == 1, 2'b01);
    chk("t6_sat", 32'(bus4.stall_cnt), 32'hF);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 2'b01);
    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 59) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0,
            2'($urandom_range(0, 3)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
